// File: rtl/pipe_run_monitor.sv
// Run-control and performance monitor: counts cycles/retires/stalls in RUN and
// halts the core on a PC breakpoint, a single-step retire count or a cycle timeout.
module pipe_run_monitor #(
  parameter int NUM_BP  = 4,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_current,
  input  logic        pc_valid,
  input  logic        retire,
  input  logic        stall,
  input  logic        we,
  input  logic [3:0]  a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        halt,
  output logic        running
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_BP   = 2'd1;
  localparam logic [1:0] CAUSE_STEP = 2'd2;
  localparam logic [1:0] CAUSE_TMO  = 2'd3;

  state_e           state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic             step_en_q, step_en_d;
  logic             mask_q, mask_d;
  logic             halt_q, running_q;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] stepc_q, stepc_d;
  logic [CNT_W-1:0] step_n_q, step_n_d;
  logic [31:0]      bp_q [NUM_BP];
  logic [31:0]      bp_d [NUM_BP];

  logic             ctrl_wr_s, start_s, clear_s, in_run_s;
  logic             bp_hit_s, bp_fire_s, step_fire_s, tmo_fire_s, any_fire_s;
  logic [CNT_W:0]   step_sum_s;
  logic [32:0]      cyc_plus_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) begin
      sat_inc = v + CNT_W'(1);
    end else begin
      sat_inc = v;
    end
  endfunction

  assign ctrl_wr_s = we && (a == 4'd0);
  assign start_s   = ctrl_wr_s && wd[0];
  assign clear_s   = ctrl_wr_s && wd[1];
  assign in_run_s  = (state_q == ST_RUN);

  // Halt-condition detection; bits [1:0] of PC and BP are excluded from the match.
  always_comb begin
    bp_hit_s = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      bp_hit_s = bp_hit_s | (bp_q[i][0] & (((pc_current ^ bp_q[i]) & 32'hFFFF_FFFC) == 32'd0));
    end
    step_sum_s  = {1'b0, stepc_q} + {{CNT_W{1'b0}}, retire};
    cyc_plus_s  = 33'(cycle_q) + 33'd1;
    bp_fire_s   = in_run_s && pc_valid && bp_hit_s && !mask_q;
    step_fire_s = in_run_s && step_en_q && (step_n_q != '0) && (step_sum_s == {1'b0, step_n_q});
    tmo_fire_s  = in_run_s && (TIMEOUT != 0) && (cyc_plus_s == 33'(TIMEOUT));
    any_fire_s  = bp_fire_s || step_fire_s || tmo_fire_s;
  end

  // Run-control FSM: next state, halt cause and the post-resume breakpoint mask.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    mask_d  = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_RUN;
          cause_d = CAUSE_NONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (pc_valid) begin
          mask_d = 1'b0;
        end else begin
          mask_d = mask_q;
        end
        if (bp_fire_s) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BP;
        end else if (step_fire_s) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_STEP;
        end else if (tmo_fire_s) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_TMO;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        if (start_s) begin
          state_d = ST_RUN;
          cause_d = CAUSE_NONE;
          mask_d  = 1'b1;
        end else begin
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cause_d = CAUSE_NONE;
        mask_d  = 1'b0;
      end
    endcase
  end

  // Counter and register-file next state; clear wins over any increment.
  always_comb begin
    cycle_d   = cycle_q;
    retire_d  = retire_q;
    stall_d   = stall_q;
    stepc_d   = stepc_q;
    step_en_d = ctrl_wr_s ? wd[2] : step_en_q;
    step_n_d  = (we && (a == 4'd4)) ? wd[CNT_W-1:0] : step_n_q;
    for (int i = 0; i < NUM_BP; i++) begin
      bp_d[i] = (we && (a == 4'(8 + i))) ? wd : bp_q[i];
    end
    if (clear_s) begin
      cycle_d  = '0;
      retire_d = '0;
      stall_d  = '0;
      stepc_d  = '0;
    end else if (in_run_s) begin
      cycle_d  = sat_inc(cycle_q, 1'b1);
      retire_d = sat_inc(retire_q, retire);
      stall_d  = sat_inc(stall_q, stall);
      stepc_d  = any_fire_s ? '0 : sat_inc(stepc_q, retire);
    end else begin
      stepc_d  = stepc_q;
    end
  end

  // Zero-latency register read mux.
  always_comb begin
    rd = 32'd0;
    case (a)
      4'd0: rd = {28'd0, cause_q, state_q};
      4'd1: rd = 32'(cycle_q);
      4'd2: rd = 32'(retire_q);
      4'd3: rd = 32'(stall_q);
      4'd4: rd = 32'(step_n_q);
      default: begin
        for (int i = 0; i < NUM_BP; i++) begin
          rd = (a == 4'(8 + i)) ? bp_q[i] : rd;
        end
      end
    endcase
  end

  // State and register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cause_q   <= CAUSE_NONE;
      step_en_q <= 1'b0;
      mask_q    <= 1'b0;
      halt_q    <= 1'b0;
      running_q <= 1'b0;
      cycle_q   <= '0;
      retire_q  <= '0;
      stall_q   <= '0;
      stepc_q   <= '0;
      step_n_q  <= '0;
      for (int i = 0; i < NUM_BP; i++) begin
        bp_q[i] <= 32'd0;
      end
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      step_en_q <= step_en_d;
      mask_q    <= mask_d;
      halt_q    <= (state_d == ST_HALTED);
      running_q <= (state_d == ST_RUN);
      cycle_q   <= cycle_d;
      retire_q  <= retire_d;
      stall_q   <= stall_d;
      stepc_q   <= stepc_d;
      step_n_q  <= step_n_d;
      for (int i = 0; i < NUM_BP; i++) begin
        bp_q[i] <= bp_d[i];
      end
    end
  end

  assign halt    = halt_q;
  assign running = running_q;

endmodule

// File: tb/tb_pipe_run_monitor.sv
// Self-checking bench for pipe_run_monitor: three instances (default, TIMEOUT=10,
// CNT_W=8) share stimulus; expectations go through a scoreboard queue.
module tb_pipe_run_monitor;

  logic        clk;
  logic        rst;
  logic [31:0] pc_current;
  logic        pc_valid, retire, stall;
  logic [3:0]  a;
  logic [31:0] wd;
  logic        we0, we1, we2;
  logic [31:0] rd0, rd1, rd2;
  logic        halt0, halt1, halt2;
  logic        running0, running1, running2;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

  pipe_run_monitor #(.NUM_BP(4), .CNT_W(32), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst), .pc_current(pc_current), .pc_valid(pc_valid),
    .retire(retire), .stall(stall), .we(we0), .a(a), .wd(wd),
    .rd(rd0), .halt(halt0), .running(running0));

  pipe_run_monitor #(.NUM_BP(4), .CNT_W(32), .TIMEOUT(10)) dut1 (
    .clk(clk), .rst(rst), .pc_current(pc_current), .pc_valid(pc_valid),
    .retire(retire), .stall(stall), .we(we1), .a(a), .wd(wd),
    .rd(rd1), .halt(halt1), .running(running1));

  pipe_run_monitor #(.NUM_BP(4), .CNT_W(8), .TIMEOUT(0)) dut2 (
    .clk(clk), .rst(rst), .pc_current(pc_current), .pc_valid(pc_valid),
    .retire(retire), .stall(stall), .we(we2), .a(a), .wd(wd),
    .rd(rd2), .halt(halt2), .running(running2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [31:0] got);
    exp_t e;
    e = sb_q.pop_front();
    check_eq(e.tag, got, e.exp);
  endtask

  function automatic logic [31:0] rd_of(input int d);
    return (d == 0) ? rd0 : ((d == 1) ? rd1 : rd2);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input int d, input logic [3:0] addr, input logic [31:0] data);
    a   = addr;
    wd  = data;
    we0 = (d == 0);
    we1 = (d == 1);
    we2 = (d == 2);
    tick();
    we0 = 1'b0;
    we1 = 1'b0;
    we2 = 1'b0;
  endtask

  task automatic expect_rd(input int d, input logic [3:0] addr, input logic [31:0] exp, input string tag);
    sb_push(tag, exp);
    a = addr;
    #1;
    sb_pop_check(rd_of(d));
  endtask

  task automatic expect_flags(input int d, input logic h, input logic r, input string tag);
    logic hh, rr;
    sb_push({tag, "_halt"}, {31'd0, h});
    sb_push({tag, "_run"}, {31'd0, r});
    hh = (d == 0) ? halt0 : ((d == 1) ? halt1 : halt2);
    rr = (d == 0) ? running0 : ((d == 1) ? running1 : running2);
    sb_pop_check({31'd0, hh});
    sb_pop_check({31'd0, rr});
  endtask

  initial begin
    rst = 1'b0; pc_current = 32'd0; pc_valid = 1'b0; retire = 1'b0; stall = 1'b0;
    a = 4'd0; wd = 32'd0; we0 = 1'b0; we1 = 1'b0; we2 = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    // Reset state: every address reads 0, flags low.
    expect_flags(0, 1'b0, 1'b0, "rst0");
    for (int i = 0; i < 16; i++) begin
      expect_rd(0, 4'(i), 32'd0, $sformatf("rst_rd%0d", i));
      tick();
    end

    // Breakpoint at 0x90, PC walks 0x0..0x90.
    wr(0, 4'd8, 32'h0000_0091);
    expect_rd(0, 4'd8, 32'h0000_0091, "bp0_rb");
    wr(0, 4'd0, 32'd1);
    expect_flags(0, 1'b0, 1'b1, "start");
    for (int i = 0; i <= 36; i++) begin
      pc_current = 32'(i * 4);
      pc_valid   = 1'b1;
      tick();
      if (i == 35) expect_flags(0, 1'b0, 1'b1, "pre_bp");
    end
    pc_valid = 1'b0;
    expect_flags(0, 1'b1, 1'b0, "bp_halt");
    expect_rd(0, 4'd0, 32'h6, "bp_status");
    expect_rd(0, 4'd1, 32'd37, "bp_cycle");
    tick();
    expect_rd(0, 4'd2, 32'd0, "bp_retire");

    // Resume: first fetch at the halting PC is masked, a later one traps.
    wr(0, 4'd0, 32'd1);
    pc_current = 32'h90; pc_valid = 1'b1;
    tick();
    expect_flags(0, 1'b0, 1'b1, "resume_mask");
    pc_current = 32'h94;
    tick();
    expect_flags(0, 1'b0, 1'b1, "resume_94");
    expect_rd(0, 4'd0, 32'h1, "resume_status");
    pc_current = 32'h90;
    tick();
    pc_valid = 1'b0;
    expect_flags(0, 1'b1, 1'b0, "retrap");
    expect_rd(0, 4'd0, 32'h6, "retrap_status");
    expect_rd(0, 4'd1, 32'd40, "retrap_cycle");

    // Register map: reserved and unused slots ignore writes, real ones read back.
    wr(0, 4'd8, 32'd0);
    wr(0, 4'd5, 32'hDEAD_BEEF);
    wr(0, 4'd12, 32'h1234_5679);
    wr(0, 4'd9, 32'hABCD_0001);
    wr(0, 4'd4, 32'd3);
    expect_rd(0, 4'd5, 32'd0, "rsvd5");
    expect_rd(0, 4'd12, 32'd0, "unused_bp");
    expect_rd(0, 4'd9, 32'hABCD_0001, "bp1_rb");
    tick();
    expect_rd(0, 4'd4, 32'd3, "stepn_rb");
    expect_rd(0, 4'd8, 32'd0, "bp0_clr");

    // Single step: STEP_N=3, retire every other cycle.
    wr(0, 4'd0, 32'h5);
    for (int k = 0; k < 6; k++) begin
      retire = (k % 2 == 1);
      tick();
      if (k == 4) expect_flags(0, 1'b0, 1'b1, "pre_step");
    end
    retire = 1'b0;
    expect_flags(0, 1'b1, 1'b0, "step_halt");
    expect_rd(0, 4'd0, 32'hA, "step_status");
    expect_rd(0, 4'd2, 32'd3, "step_retire");

    // Timeout on dut1, then reset with a concurrent start write.
    wr(1, 4'd0, 32'd1);
    for (int j = 0; j < 10; j++) begin
      tick();
      if (j == 8) expect_flags(1, 1'b0, 1'b1, "pre_tmo");
    end
    expect_flags(1, 1'b1, 1'b0, "tmo_halt");
    expect_rd(1, 4'd0, 32'hE, "tmo_status");
    expect_rd(1, 4'd1, 32'd10, "tmo_cycle");
    tick();
    a = 4'd0; wd = 32'd1; we1 = 1'b1; rst = 1'b0;
    tick();
    we1 = 1'b0; rst = 1'b1;
    expect_flags(1, 1'b0, 1'b0, "rst_mid");
    expect_rd(1, 4'd0, 32'd0, "rst_status");
    expect_rd(1, 4'd1, 32'd0, "rst_cycle");

    // Saturation on the 8-bit instance, then clear while running.
    tick();
    wr(2, 4'd0, 32'd1);
    stall = 1'b1;
    repeat (300) tick();
    expect_rd(2, 4'd3, 32'hFF, "sat_stall");
    expect_rd(2, 4'd1, 32'hFF, "sat_cycle");
    expect_flags(2, 1'b0, 1'b1, "sat_run");
    wr(2, 4'd0, 32'd2);
    expect_rd(2, 4'd3, 32'd0, "clr_stall");
    expect_rd(2, 4'd1, 32'd0, "clr_cycle");
    expect_flags(2, 1'b0, 1'b1, "clr_run");
    tick();
    expect_rd(2, 4'd3, 32'd1, "post_clr_stall");
    expect_rd(2, 4'd1, 32'd1, "post_clr_cycle");
    stall = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
